// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared types and helpers for the systolic tile controller.
//   state_t     : one-hot controller state (LOAD / MAC / OUT)
//   mac_cycles  : length of the MAC phase for a given tile geometry
//   cnt_width   : bits needed to hold a counter value in 0..max_val
// -----------------------------------------------------------------------------
package systolic_pkg;

    typedef enum logic [2:0] {
        S_LOAD = 3'b001,
        S_MAC  = 3'b010,
        S_OUT  = 3'b100
    } state_t;

    // The last PE (row ROWS-1, column COLS-1) sees its final operand pair
    // DEPTH-1 + (ROWS-1) + (COLS-1) cycles after the first read.
    function automatic int unsigned mac_cycles(input int unsigned depth,
                                               input int unsigned rows,
                                               input int unsigned cols);
        return depth + rows + cols - 2;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/systolic_tile_ctrl_if.sv
// -----------------------------------------------------------------------------
// systolic_tile_ctrl_if
// Operand-stream and result-row handshakes of the systolic tile controller.
//   x_send_val/x_send_rdy : x operand stream
//   w_send_val/w_send_rdy : w operand stream
//   out_val/out_rdy       : result-row handshake
//   out_row               : index of the result row being presented
// Modports: master = producer/consumer side, slave = controller side.
// -----------------------------------------------------------------------------
interface systolic_tile_ctrl_if #(
    parameter int unsigned ROWS = 4
) ();

    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic          x_send_val;
    logic          x_send_rdy;
    logic          w_send_val;
    logic          w_send_rdy;
    logic          out_val;
    logic          out_rdy;
    logic [RW-1:0] out_row;

    modport master (
        output x_send_val, w_send_val, out_rdy,
        input  x_send_rdy, w_send_rdy, out_val, out_row
    );

    modport slave (
        input  x_send_val, w_send_val, out_rdy,
        output x_send_rdy, w_send_rdy, out_val, out_row
    );

endinterface

// File: rtl/systolic_skew_chain.sv
// -----------------------------------------------------------------------------
// systolic_skew_chain
// Diagonal read-enable skew: ren_o[0] follows head_i directly, ren_o[i] is
// ren_o[i-1] delayed by one cycle. While en_i is low the delay line is
// flushed and all outputs are held at 0.
//   clk, rst_n : clock, synchronous active-low reset
//   en_i       : skew active (controller in MAC)
//   head_i     : read enable for lane 0
//   ren_o[N]   : skewed read enables
// -----------------------------------------------------------------------------
module systolic_skew_chain #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         head_i,
    output logic [N-1:0] ren_o
);

    if (N > 1) begin : g_chain
        logic [N-2:0] dly_q;
        logic [N-1:0] taps;

        assign taps  = {dly_q, head_i};
        assign ren_o = en_i ? taps : '0;

        always_ff @(posedge clk) begin
            if (!rst_n || !en_i) begin
                dly_q <= '0;
            end else begin
                dly_q <= taps[N-2:0];
            end
        end
    end else begin : g_single
        assign ren_o = en_i ? head_i : 1'b0;
    end

endmodule

// File: rtl/systolic_tile_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_tile_ctrl
// Sequences one systolic tile: LOAD operands into the row/column FIFOs,
// stream them diagonally into the PE array (MAC), then hand out result rows
// (OUT). Returns to LOAD after the last row so tiles run back-to-back.
//   clk, rst_n              : clock, synchronous active-low reset
//   io (slave)              : x/w send handshakes, out_val/out_rdy, out_row
//   x_fifo_full/empty [ROWS]: row FIFO status
//   x_fifo_wen/ren   [ROWS] : row FIFO write / skewed read enables
//   w_fifo_full/empty [COLS]: column FIFO status
//   w_fifo_wen/ren   [COLS] : column FIFO write / skewed read enables
//   mac_en                  : PE accumulate enable (high for all of MAC)
//   acc_clr                 : pulse with the final result-row handshake
//   busy                    : state is not LOAD
//   stall_cnt [32]          : OUT back-pressure cycles, saturating; only
//                             present with SYSTOLIC_TILE_CTRL_PERF_EN
// -----------------------------------------------------------------------------
module systolic_tile_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COLS  = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    systolic_tile_ctrl_if.slave io,
    input  logic [ROWS-1:0]     x_fifo_full,
    input  logic [ROWS-1:0]     x_fifo_empty,
    output logic [ROWS-1:0]     x_fifo_wen,
    output logic [ROWS-1:0]     x_fifo_ren,
    input  logic [COLS-1:0]     w_fifo_full,
    input  logic [COLS-1:0]     w_fifo_empty,
    output logic [COLS-1:0]     w_fifo_wen,
    output logic [COLS-1:0]     w_fifo_ren,
    output logic                mac_en,
    output logic                acc_clr,
    output logic                busy
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);

    localparam int unsigned MAC_LEN = mac_cycles(DEPTH, ROWS, COLS);
    localparam int unsigned CW      = cnt_width(DEPTH);
    localparam int unsigned MW      = cnt_width(MAC_LEN);
    localparam int unsigned RW      = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [MW-1:0] DEPTH_M   = MW'(DEPTH);
    localparam logic [MW-1:0] MAC_LAST  = MW'(MAC_LEN - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] x_cnt_q, x_cnt_d;
    logic [CW-1:0] w_cnt_q, w_cnt_d;
    logic [MW-1:0] mac_cnt_q, mac_cnt_d;
    logic [RW-1:0] out_row_q, out_row_d;

    logic x_rdy, w_rdy, x_xfer, w_xfer;
    logic in_mac, ren_head, out_val;

    // FIFO empties are status only; the controller never consults them.
    logic unused_fifo_empty;
    assign unused_fifo_empty = ^{x_fifo_empty, w_fifo_empty};

    always_comb begin
        state_d   = state_q;
        x_cnt_d   = x_cnt_q;
        w_cnt_d   = w_cnt_q;
        mac_cnt_d = mac_cnt_q;
        out_row_d = out_row_q;
        x_rdy     = 1'b0;
        w_rdy     = 1'b0;
        x_xfer    = 1'b0;
        w_xfer    = 1'b0;
        in_mac    = 1'b0;
        ren_head  = 1'b0;
        out_val   = 1'b0;
        acc_clr   = 1'b0;

        case (state_q)
            S_LOAD: begin
                // Ready is masked during reset so no FIFO write can slip in.
                x_rdy  = rst_n && (x_cnt_q < DEPTH_C) && !(|x_fifo_full);
                w_rdy  = rst_n && (w_cnt_q < DEPTH_C) && !(|w_fifo_full);
                x_xfer = io.x_send_val && x_rdy;
                w_xfer = io.w_send_val && w_rdy;
                if (x_xfer) x_cnt_d = x_cnt_q + CW'(1);
                if (w_xfer) w_cnt_d = w_cnt_q + CW'(1);
                if (x_cnt_q == DEPTH_C && w_cnt_q == DEPTH_C) begin
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                in_mac    = 1'b1;
                ren_head  = (mac_cnt_q < DEPTH_M);
                mac_cnt_d = mac_cnt_q + MW'(1);
                if (mac_cnt_q == MAC_LAST) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                out_val = 1'b1;
                if (io.out_rdy) begin
                    if (out_row_q == ROW_LAST) begin
                        acc_clr   = 1'b1;
                        state_d   = S_LOAD;
                        x_cnt_d   = '0;
                        w_cnt_d   = '0;
                        mac_cnt_d = '0;
                        out_row_d = '0;
                    end else begin
                        out_row_d = out_row_q + RW'(1);
                    end
                end
            end
            default: begin
                state_d   = S_LOAD;
                x_cnt_d   = '0;
                w_cnt_d   = '0;
                mac_cnt_d = '0;
                out_row_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_LOAD;
            x_cnt_q   <= '0;
            w_cnt_q   <= '0;
            mac_cnt_q <= '0;
            out_row_q <= '0;
        end else begin
            state_q   <= state_d;
            x_cnt_q   <= x_cnt_d;
            w_cnt_q   <= w_cnt_d;
            mac_cnt_q <= mac_cnt_d;
            out_row_q <= out_row_d;
        end
    end

    systolic_skew_chain #(.N(ROWS)) u_x_skew (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (in_mac),
        .head_i (ren_head),
        .ren_o  (x_fifo_ren)
    );

    systolic_skew_chain #(.N(COLS)) u_w_skew (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (in_mac),
        .head_i (ren_head),
        .ren_o  (w_fifo_ren)
    );

    assign io.x_send_rdy = x_rdy;
    assign io.w_send_rdy = w_rdy;
    assign io.out_val    = out_val;
    assign io.out_row    = out_row_q;
    assign x_fifo_wen    = {ROWS{x_xfer}};
    assign w_fifo_wen    = {COLS{w_xfer}};
    assign mac_en        = in_mac;
    assign busy          = (state_q != S_LOAD);

`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (state_q == S_OUT && !io.out_rdy && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
